// File: rtl/sobel_window_gen.sv
// Raster-to-3x3 window generator: two column-indexed line RAMs plus a shifting 3x3 register window.
// Optional SOBEL_WINDOW_GEN_FRAME_DONE_EN adds o_frame_done on the final window of a frame.
module sobel_window_gen #(
  parameter int DW    = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [DW-1:0]   i_pix,
  input  logic            i_pix_valid,
  input  logic            i_sof,
  output logic [9*DW-1:0] o_window,
`ifdef SOBEL_WINDOW_GEN_FRAME_DONE_EN
  output logic            o_frame_done,
`endif
  output logic            o_valid
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(2);
  localparam logic [RW-1:0] ROW_MIN  = RW'(2);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col, col_cur, col_nxt;
  logic [RW-1:0] row, row_cur, row_nxt;
  logic          accept;
  logic          last_pix;
  logic [DW-1:0] top, mid;
  logic [DW-1:0] lb1 [IMG_W];
  logic [DW-1:0] lb2 [IMG_W];

  // i_sof forces the accepted pixel to (0,0) regardless of state, which also covers resync
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_pix  = 1'b0;
    col_cur   = col;
    row_cur   = row;
    col_nxt   = col;
    row_nxt   = row;
    if (i_pix_valid && (i_sof || state == ACTIVE)) begin
      accept = 1'b1;
      if (i_sof) begin
        col_cur = '0;
        row_cur = '0;
      end
      last_pix  = (col_cur == COL_LAST) && (row_cur == ROW_LAST);
      state_nxt = last_pix ? IDLE : ACTIVE;
      if (col_cur == COL_LAST) begin
        col_nxt = '0;
        row_nxt = last_pix ? '0 : row_cur + RW'(1);
      end else begin
        col_nxt = col_cur + CW'(1);
        row_nxt = row_cur;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
    end
  end

  assign top = lb2[col_cur];
  assign mid = lb1[col_cur];

  // Line RAMs: read-before-write, lb1 rolls down into lb2
  always_ff @(posedge i_clk) begin
    if (accept) begin
      lb2[col_cur] <= lb1[col_cur];
      lb1[col_cur] <= i_pix;
    end
  end

  // Output stage: window shifts left, new right column enters slots 2/5/8
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_valid  <= 1'b0;
      o_window <= '0;
    end else begin
      o_valid <= accept && (col_cur >= COL_MIN) && (row_cur >= ROW_MIN);
      if (accept) begin
        o_window <= {i_pix, o_window[8*DW +: DW], o_window[7*DW +: DW],
                     mid,   o_window[5*DW +: DW], o_window[4*DW +: DW],
                     top,   o_window[2*DW +: DW], o_window[1*DW +: DW]};
      end
    end
  end

`ifdef SOBEL_WINDOW_GEN_FRAME_DONE_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= accept && last_pix;
    end
  end
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen at 4x3: vector table plus queue scoreboard checked on the falling edge.
module tb_sobel_window_gen;

  localparam int DW = 8;
  localparam logic [71:0] W1 = 72'h22_21_20_12_11_10_02_01_00;
  localparam logic [71:0] W2 = 72'h23_22_21_13_12_11_03_02_01;

  logic          clk = 1'b0;
  logic          i_rstn;
  logic [DW-1:0] i_pix;
  logic          i_pix_valid;
  logic          i_sof;
  logic [71:0]   o_window;
  logic          o_valid;
`ifdef SOBEL_WINDOW_GEN_FRAME_DONE_EN
  logic          o_frame_done;
`endif

  sobel_window_gen #(.DW(DW), .IMG_W(4), .IMG_H(3)) dut (
    .i_clk       (clk),
    .i_rstn      (i_rstn),
    .i_pix       (i_pix),
    .i_pix_valid (i_pix_valid),
    .i_sof       (i_sof),
    .o_window    (o_window),
`ifdef SOBEL_WINDOW_GEN_FRAME_DONE_EN
    .o_frame_done(o_frame_done),
`endif
    .o_valid     (o_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  pix;
    logic        sof;
    logic        exp_vld;
    logic [71:0] exp_win;
    logic        exp_fd;
  } vec_t;

  typedef struct {
    logic [71:0] win;
    int          due;
    logic        fd;
  } exp_t;

  vec_t tbl [12];
  exp_t sbq [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic [7:0] p, input logic s, input logic v);
    @(posedge clk);
    #1;
    i_pix       = p;
    i_sof       = s;
    i_pix_valid = v;
  endtask

  task automatic apply(input int first, input int last, input int maxgap);
    exp_t e;
    for (int i = first; i <= last; i++) begin
      if (maxgap > 0) repeat ($urandom_range(1, maxgap)) drive(8'h00, 1'b0, 1'b0);
      drive(tbl[i].pix, tbl[i].sof, 1'b1);
      if (tbl[i].exp_vld) begin
        e.win = tbl[i].exp_win;
        e.due = cyc + 1;
        e.fd  = tbl[i].exp_fd;
        sbq.push_back(e);
      end
    end
    drive(8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t got;
    for (int i = 0; i < 12; i++) begin
      tbl[i].pix     = 8'(((i / 4) * 16) + (i % 4));
      tbl[i].sof     = (i == 0);
      tbl[i].exp_vld = 1'b0;
      tbl[i].exp_win = '0;
      tbl[i].exp_fd  = 1'b0;
    end
    tbl[10].exp_vld = 1'b1; tbl[10].exp_win = W1;
    tbl[11].exp_vld = 1'b1; tbl[11].exp_win = W2; tbl[11].exp_fd = 1'b1;

    i_rstn = 1'b0; i_pix = '0; i_pix_valid = 1'b0; i_sof = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_valid", 72'(o_valid), 72'd0);
    check("reset_window", o_window, 72'd0);
`ifdef SOBEL_WINDOW_GEN_FRAME_DONE_EN
    check("reset_frame_done", 72'(o_frame_done), 72'd0);
`endif
    i_rstn = 1'b1;

    // Falling-edge monitor: every strobe must match the queue head on its due cycle
    fork
      forever begin
        @(negedge clk);
        while (sbq.size() > 0 && sbq[0].due < cyc) begin
          got = sbq.pop_front();
          check("missed_strobe", 72'd0, got.win);
        end
`ifdef SOBEL_WINDOW_GEN_FRAME_DONE_EN
        if (o_frame_done && !o_valid) check("frame_done_without_valid", 72'd1, 72'd0);
`endif
        if (o_valid) begin
          if (sbq.size() == 0) begin
            check("unexpected_strobe", o_window, 72'd0);
          end else begin
            got = sbq.pop_front();
            check("strobe_cycle", 72'(cyc), 72'(got.due));
            check("window", o_window, got.win);
`ifdef SOBEL_WINDOW_GEN_FRAME_DONE_EN
            check("frame_done", 72'(o_frame_done), 72'(got.fd));
`endif
          end
        end
      end
    join_none

    // Basic frame, back-to-back
    apply(0, 11, 0);
    repeat (3) drive(8'h00, 1'b0, 1'b0);

    // Pixels after frame end without i_sof, plus a bare i_sof, are ignored
    drive(8'h77, 1'b0, 1'b1);
    drive(8'h78, 1'b0, 1'b1);
    drive(8'h79, 1'b1, 1'b0);
    drive(8'h7A, 1'b0, 1'b1);
    drive(8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check("window_hold_idle", o_window, W2);

    // Stalls of 1-5 cycles between pixels
    apply(0, 11, 5);
    repeat (3) drive(8'h00, 1'b0, 1'b0);

    // Pre-SOF junk
    for (int j = 0; j < 5; j++) drive(8'hFF, 1'b0, 1'b1);
    apply(0, 11, 0);
    repeat (3) drive(8'h00, 1'b0, 1'b0);

    // Resync: abort after (1,1) so the next i_sof lands on (1,2)
    apply(0, 5, 0);
    apply(0, 11, 0);
    repeat (3) drive(8'h00, 1'b0, 1'b0);

    // Asynchronous reset while a window is being shown
    apply(0, 10, 0);
    @(negedge clk);
    #2;
    check("pre_reset_window", o_window, W1);
    i_rstn = 1'b0;
    #1;
    check("async_reset_valid", 72'(o_valid), 72'd0);
    check("async_reset_window", o_window, 72'd0);
    @(posedge clk);
    #1;
    i_rstn = 1'b1;
    drive(tbl[11].pix, 1'b0, 1'b1);
    drive(8'h00, 1'b0, 1'b0);
    apply(0, 11, 0);
    repeat (5) drive(8'h00, 1'b0, 1'b0);

    check("scoreboard_drained", 72'(sbq.size()), 72'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Converts a raster pixel stream (one DW-bit pixel per valid cycle, row-major) into 3x3 neighbourhood windows.
- Output is in the flat 9*DW format consumed by the sobel convolution stage.
- Sits between the camera capture/greyscale path and the convolution stage; drives its window data and valid inputs directly.
- No backpressure exists in either direction.

Parameters:
- DW, 8, pixel width in bits
- IMG_W, 640, active pixels per line; minimum 3
- IMG_H, 480, active lines per frame; minimum 3

Ports:
- i_clk  input  1  system clock
- i_rstn  input  1  asynchronous active-low reset
- i_pix  input  DW  pixel data
- i_pix_valid  input  1  pixel accepted on this edge when high
- i_sof  input  1  start of frame; qualified by i_pix_valid; marks pixel (row 0, col 0)
- o_window  output  9*DW  3x3 window; slot k at [k*DW +: DW]; k=0..2 top row L->R, 3..5 middle row, 6..8 bottom row
- o_valid  output  1  one-cycle strobe, o_window valid

Behaviour:
- Reset is asynchronous, active-low. On reset: o_valid=0, o_window=0, col=0, row=0, state=IDLE.
- Line RAM contents are not reset.
- State IDLE:
  - Accepted pixels without i_sof are ignored.
  - An accepted pixel with i_sof is processed as (0,0); go ACTIVE with col=1, row=0.
- State ACTIVE, on each accepted pixel at (row, col):
  - Two line RAMs, depth IMG_W, indexed by col, read-before-write in the same cycle. lb1 holds the previous line; lb2 holds the line before that.
  - Read top=lb2[col] and mid=lb1[col], then write lb2[col]<=lb1[col] and lb1[col]<=i_pix.
  - Window registers shift one column left. The new right column is (top, mid, i_pix) into slots 2, 5, 8.
  - col increments. At col=IMG_W-1 it wraps to 0 and row increments.
  - After pixel (IMG_H-1, IMG_W-1), return to IDLE.
- Output gating:
  - o_valid=1 on the cycle after accepting a pixel with row>=2 and col>=2; otherwise 0.
  - The emitted window is centred on (row-1, col-1). No border padding.
  - Exactly (IMG_W-2)*(IMG_H-2) strobes per complete frame.
- Latency is 1 clock from the accepting edge to the o_valid/o_window update.
- o_window holds its last value when no pixel is accepted.
- i_pix_valid gaps of any length (including within a line) only stall the pipeline. No data is lost or duplicated.
- i_sof while ACTIVE resynchronises: the pixel becomes (0,0), counters restart, and no strobe is emitted for it. Stale RAM contents are never emitted because rows 0-1 are rewritten before any window uses them.
- i_sof without i_pix_valid is ignored.
- Pixels arriving in IDLE after frame end are ignored until the next i_sof.
- Counter widths are $clog2(IMG_W) and $clog2(IMG_H). Only the listed counter wrap/reset conditions occur.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously); the next frame requires i_sof.

Optional Feature:
- Macro: SOBEL_WINDOW_GEN_FRAME_DONE_EN.
- When defined:
  - Adds output port o_frame_done (1 bit, reset 0).
  - o_frame_done is a one-cycle pulse coincident with the final o_valid of a frame, i.e. the window for pixel (IMG_H-1, IMG_W-1).
  - No pulse is emitted for a frame aborted by i_sof or reset.
- When undefined: the port and its logic do not exist; all other behaviour is identical.

Test Plan:
- Bench uses IMG_W=4, IMG_H=3, DW=8, pixel value = row*16+col.
- Basic frame: i_sof on the first pixel, 12 back-to-back pixels.
  - Exactly 2 strobes.
  - First strobe, one cycle after pixel 0x22: slots0..8 = 00,01,02,10,11,12,20,21,22.
  - Second strobe: 01,02,03,11,12,13,21,22,23.
- Stalls: same frame with i_pix_valid low for 1-5 random cycles between pixels -> identical 2 windows, each 1 cycle after its 0x22 or 0x23 pixel.
- Pre-SOF junk: 5 pixels of 0xFF with i_sof=0, then the basic frame -> output identical to the basic frame; no strobe during the junk.
- Resync: i_sof asserted at pixel (1,2) of a frame, then a full frame -> no strobe until the restarted frame's pixel (2,2), and the windows match the basic frame.
- Reset: i_rstn low during pixel (2,2) -> o_valid=0 and o_window=0 asynchronously; the following full frame produces the basic-frame result.
- With SOBEL_WINDOW_GEN_FRAME_DONE_EN: basic frame -> o_frame_done high only with the second strobe. Resync case -> no pulse for the aborted frame.
